// File: rtl/regfile_mp_pkg.sv
// Shared constants and the register-address type used by decode, writeback and the register file.
package regfile_mp_pkg;
  localparam int WIDTH_DEF  = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int NRD_DEF    = 2;
  localparam int NWR_DEF    = 2;

  typedef logic [ADDR_W_DEF-1:0] reg_addr_t;
endpackage

// File: rtl/regfile_mp_read_port.sv
// One combinational read port: stored value, optional same-cycle write forwarding, x0 and reset masking.
module rf_read_port #(
  parameter int WIDTH    = 32,
  parameter int ADDR_W   = 5,
  parameter int NWR      = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                  rst_n,
  input  logic [ADDR_W-1:0]     raddr,
  input  logic [WIDTH-1:0]      stored,
  input  logic [NWR-1:0]        wen,
  input  logic [NWR*ADDR_W-1:0] waddr,
  input  logic [NWR*WIDTH-1:0]  wdata,
  output logic [WIDTH-1:0]      rdata
);
  always_comb begin
    rdata = stored;
    // Later ports override earlier ones so the forwarded value matches the write that lands.
    for (int j = 0; j < NWR; j++) begin
      if (BYPASS != 0 && wen[j] && waddr[j*ADDR_W +: ADDR_W] == raddr) begin
        rdata = wdata[j*WIDTH +: WIDTH];
      end
    end
    if ((ZERO_REG != 0 && raddr == '0) || !rst_n) begin
      rdata = '0;
    end
  end
endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with per-register busy scoreboard and registered busy population count.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int WIDTH    = WIDTH_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NRD      = NRD_DEF,
  parameter int NWR      = NWR_DEF,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NRD*ADDR_W-1:0] raddr,
  output logic [NRD*WIDTH-1:0]  rdata,
  output logic [NRD-1:0]        rbusy,
  input  logic [NWR-1:0]        wen,
  input  logic [NWR*ADDR_W-1:0] waddr,
  input  logic [NWR*WIDTH-1:0]  wdata,
  input  logic [NWR-1:0]        wclr,
  input  logic                  alloc_en,
  input  logic [ADDR_W-1:0]     alloc_addr,
  output logic [ADDR_W:0]       busy_cnt
);
  localparam int DEPTH = 2**ADDR_W;

  logic [WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] busy_nxt;
  logic [ADDR_W:0]  cnt_nxt;

  // Clears first, alloc last: a new producer supersedes the one retiring in the same cycle.
  always_comb begin
    busy_nxt = busy;
    for (int i = 0; i < NWR; i++) begin
      if (wen[i] && wclr[i]) begin
        busy_nxt[waddr[i*ADDR_W +: ADDR_W]] = 1'b0;
      end
    end
    if (alloc_en) begin
      busy_nxt[alloc_addr] = 1'b1;
    end
    if (ZERO_REG != 0) begin
      busy_nxt[0] = 1'b0;
    end
    cnt_nxt = '0;
    for (int k = 0; k < DEPTH; k++) begin
      cnt_nxt = cnt_nxt + (ADDR_W+1)'(busy_nxt[k]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        regs[k] <= '0;
      end
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      // Ascending loop: the highest enabled port targeting an address is the last assignment.
      for (int i = 0; i < NWR; i++) begin
        if (wen[i] && !(ZERO_REG != 0 && waddr[i*ADDR_W +: ADDR_W] == '0)) begin
          regs[waddr[i*ADDR_W +: ADDR_W]] <= wdata[i*WIDTH +: WIDTH];
        end
      end
      busy     <= busy_nxt;
      busy_cnt <= cnt_nxt;
    end
  end

  for (genvar r = 0; r < NRD; r++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    assign ra = raddr[r*ADDR_W +: ADDR_W];

    rf_read_port #(
      .WIDTH    (WIDTH),
      .ADDR_W   (ADDR_W),
      .NWR      (NWR),
      .BYPASS   (BYPASS),
      .ZERO_REG (ZERO_REG)
    ) u_port (
      .rst_n  (rst_n),
      .raddr  (ra),
      .stored (regs[ra]),
      .wen    (wen),
      .waddr  (waddr),
      .wdata  (wdata),
      .rdata  (rdata[r*WIDTH +: WIDTH])
    );

    // Registered state only, so a same-cycle alloc or clear shows up one cycle later.
    assign rbusy[r] = rst_n & busy[ra];
  end
endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: vector table plus hand sequences for collisions, races, x0, sweep and reset.
module tb_regfile_mp;
  import regfile_mp_pkg::*;

  localparam int W   = 32;
  localparam int AW  = 5;
  localparam int NRD = 2;
  localparam int NWR = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NRD*AW-1:0] raddr;
  logic [NRD*W-1:0]  rdata, rdata_nb;
  logic [NRD-1:0]    rbusy, rbusy_nb;
  logic [NWR-1:0]    wen, wclr;
  logic [NWR*AW-1:0] waddr;
  logic [NWR*W-1:0]  wdata;
  logic              alloc_en;
  logic [AW-1:0]     alloc_addr;
  logic [AW:0]       busy_cnt, busy_cnt_nb;

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];

  // Clock/reset
  always #5 clk = ~clk;

  regfile_mp #(.BYPASS(1)) dut (
    .clk(clk), .rst_n(rst_n), .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
    .wen(wen), .waddr(waddr), .wdata(wdata), .wclr(wclr),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr), .busy_cnt(busy_cnt)
  );

  regfile_mp #(.BYPASS(0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .raddr(raddr), .rdata(rdata_nb), .rbusy(rbusy_nb),
    .wen(wen), .waddr(waddr), .wdata(wdata), .wclr(wclr),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr), .busy_cnt(busy_cnt_nb)
  );

  // Driver tasks
  task automatic idle();
    wen = '0; wclr = '0; waddr = '0; wdata = '0;
    alloc_en = 1'b0; alloc_addr = '0;
  endtask

  task automatic wr(input int p, input reg_addr_t a, input logic [W-1:0] d, input logic clr);
    wen[p] = 1'b1;
    wclr[p] = clr;
    waddr[p*AW +: AW] = a;
    wdata[p*W +: W] = d;
  endtask

  task automatic rd(input int p, input reg_addr_t a);
    raddr[p*AW +: AW] = a;
  endtask

  task automatic alloc(input reg_addr_t a);
    alloc_en = 1'b1;
    alloc_addr = a;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard
  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_q(input string name, input logic [W-1:0] act);
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: scoreboard queue empty, got 0x%08h", name, act);
    end else begin
      check(name, act, exp_q.pop_front());
    end
  endtask

  typedef struct {
    logic [1:0]  we;
    reg_addr_t   wa0, wa1;
    logic [31:0] wd0, wd1;
    logic [1:0]  clr;
    logic        al;
    reg_addr_t   aa;
    reg_addr_t   ra0, ra1;
    logic [31:0] e0, e1;
    logic [1:0]  eb;
    logic [5:0]  ec;
  } vec_t;

  vec_t tbl[6];

  initial begin
    tbl[0] = '{2'b11, 5'd1,  5'd2, 32'h100,      32'h200, 2'b00, 1'b0, 5'd0, 5'd1,  5'd2, 32'h100,      32'h200, 2'b00, 6'd0};
    tbl[1] = '{2'b01, 5'd3,  5'd0, 32'h33,       32'h0,   2'b00, 1'b1, 5'd3, 5'd3,  5'd1, 32'h33,       32'h100, 2'b01, 6'd1};
    tbl[2] = '{2'b00, 5'd0,  5'd0, 32'h0,        32'h0,   2'b00, 1'b1, 5'd4, 5'd3,  5'd4, 32'h33,       32'h0,   2'b11, 6'd2};
    tbl[3] = '{2'b10, 5'd0,  5'd3, 32'h0,        32'h3A,  2'b10, 1'b0, 5'd0, 5'd3,  5'd2, 32'h3A,       32'h200, 2'b00, 6'd1};
    tbl[4] = '{2'b11, 5'd4,  5'd4, 32'h44,       32'h45,  2'b11, 1'b0, 5'd0, 5'd4,  5'd1, 32'h45,       32'h100, 2'b00, 6'd0};
    tbl[5] = '{2'b01, 5'd31, 5'd0, 32'hFFFFFFFF, 32'h0,   2'b00, 1'b0, 5'd0, 5'd31, 5'd0, 32'hFFFFFFFF, 32'h0,   2'b00, 6'd0};

    // Reset held with writes, alloc and a bypass-eligible read all active
    rst_n = 1'b0;
    idle();
    raddr = '0;
    wr(0, 5'd7, 32'hABCD, 1'b0);
    alloc(5'd7);
    rd(0, 5'd7);
    #1;
    check("reset_rdata_bypass", rdata[0 +: W], 32'h0);
    check("reset_rbusy", 32'(rbusy), 32'h0);
    check("reset_busy_cnt", 32'(busy_cnt), 32'h0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    #1;
    check("reset_write_discarded", rdata[0 +: W], 32'h0);
    check("reset_alloc_discarded", 32'(busy_cnt), 32'h0);

    // Vector table: apply one cycle, then read back with writes idle
    for (int i = 0; i < 6; i++) begin
      idle();
      if (tbl[i].we[0]) wr(0, tbl[i].wa0, tbl[i].wd0, tbl[i].clr[0]);
      if (tbl[i].we[1]) wr(1, tbl[i].wa1, tbl[i].wd1, tbl[i].clr[1]);
      if (tbl[i].al) alloc(tbl[i].aa);
      tick();
      idle();
      rd(0, tbl[i].ra0);
      rd(1, tbl[i].ra1);
      exp_q.push_back(tbl[i].e0);
      exp_q.push_back(tbl[i].e1);
      exp_q.push_back(32'(tbl[i].eb));
      exp_q.push_back(32'(tbl[i].ec));
      #1;
      check_q($sformatf("vec%0d_rdata0", i), rdata[0 +: W]);
      check_q($sformatf("vec%0d_rdata1", i), rdata[W +: W]);
      check_q($sformatf("vec%0d_rbusy", i), 32'(rbusy));
      check_q($sformatf("vec%0d_busy_cnt", i), 32'(busy_cnt));
    end

    // Same-cycle write collision on x7
    idle();
    rd(0, 5'd7);
    wr(0, 5'd7, 32'h11, 1'b0);
    wr(1, 5'd7, 32'h22, 1'b0);
    #1;
    check("collision_bypass", rdata[0 +: W], 32'h22);
    check("collision_nobypass_old", rdata_nb[0 +: W], 32'h0);
    tick();
    idle();
    #1;
    check("collision_stored", rdata[0 +: W], 32'h22);
    check("collision_stored_nb", rdata_nb[0 +: W], 32'h22);

    // Alloc vs clearing write race on busy x5
    alloc(5'd5);
    tick();
    idle();
    #1;
    check("race_pre_cnt", 32'(busy_cnt), 32'd1);
    alloc(5'd5);
    wr(0, 5'd5, 32'h9, 1'b1);
    rd(0, 5'd5);
    tick();
    idle();
    #1;
    check("race_data", rdata[0 +: W], 32'h9);
    check("race_busy", 32'(rbusy[0]), 32'd1);
    check("race_cnt", 32'(busy_cnt), 32'd1);

    // x0 is hardwired: write and alloc both ignored
    wr(0, 5'd0, 32'hDEADBEEF, 1'b0);
    alloc(5'd0);
    rd(0, 5'd0);
    #1;
    check("x0_bypass_masked", rdata[0 +: W], 32'h0);
    tick();
    idle();
    #1;
    check("x0_rdata", rdata[0 +: W], 32'h0);
    check("x0_rbusy", 32'(rbusy[0]), 32'd0);
    check("x0_busy_cnt", 32'(busy_cnt), 32'd1);

    // Forwarding on vs off: x3 currently 0x3A
    rd(0, 5'd3);
    wr(0, 5'd3, 32'hA5, 1'b0);
    #1;
    check("bypass_on_new", rdata[0 +: W], 32'hA5);
    check("bypass_off_old", rdata_nb[0 +: W], 32'h3A);
    tick();
    idle();
    #1;
    check("bypass_off_next", rdata_nb[0 +: W], 32'hA5);

    // Count sweep: x5 is already busy, so re-allocating it must not double-count
    for (int a = 1; a <= 31; a++) begin
      idle();
      alloc(reg_addr_t'(a));
      tick();
      if (a == 10) check("sweep_cnt_10", 32'(busy_cnt), 32'd10);
    end
    idle();
    #1;
    check("sweep_cnt_full", 32'(busy_cnt), 32'd31);
    for (int k = 0; k < 16; k++) begin
      idle();
      wr(0, reg_addr_t'(2*k+1), 32'(2*k+1), 1'b1);
      if (2*k+2 <= 31) wr(1, reg_addr_t'(2*k+2), 32'(2*k+2), 1'b1);
      tick();
    end
    idle();
    #1;
    check("sweep_cnt_cleared", 32'(busy_cnt), 32'd0);
    wr(0, 5'd9, 32'h99, 1'b1);
    tick();
    idle();
    rd(0, 5'd9);
    #1;
    check("redundant_clear_cnt", 32'(busy_cnt), 32'd0);
    check("redundant_clear_data", rdata[0 +: W], 32'h99);

    // Reset flush mid-operation
    wr(0, 5'd4, 32'd50, 1'b0);
    alloc(5'd6);
    tick();
    idle();
    rd(0, 5'd4);
    #1;
    check("flush_pre_data", rdata[0 +: W], 32'd50);
    check("flush_pre_cnt", 32'(busy_cnt), 32'd1);
    wr(0, 5'd4, 32'h77, 1'b0);
    alloc(5'd9);
    #1;
    rst_n = 1'b0;
    #1;
    check("flush_rdata", rdata[0 +: W], 32'h0);
    check("flush_cnt", 32'(busy_cnt), 32'd0);
    @(posedge clk);
    #1;
    idle();
    #1;
    check("flush_write_dropped", rdata[0 +: W], 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    wr(0, 5'd4, 32'h5, 1'b0);
    alloc(5'd2);
    tick();
    idle();
    rd(1, 5'd2);
    #1;
    check("post_reset_write", rdata[0 +: W], 32'h5);
    check("post_reset_alloc", 32'(busy_cnt), 32'd1);
    check("post_reset_rbusy", 32'(rbusy[1]), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
